// File: rtl/mem_spi_pkg.sv
// Shared opcodes, frame size and FSM encoding for the CPU-memory to SPI SRAM bridge.
package mem_spi_pkg;

    localparam int         FRAME_BITS = 32;
    localparam logic [7:0] OP_READ    = 8'h03;
    localparam logic [7:0] OP_WRITE   = 8'h02;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bridgeStateT;

    // {opcode, 16-bit address, data byte}; a read carries a zero data byte.
    function automatic logic [FRAME_BITS-1:0] buildFrame(
        input logic        isWrite,
        input logic [15:0] addr,
        input logic [7:0]  data
    );
        return {isWrite ? OP_WRITE : OP_READ, addr, isWrite ? data : 8'h00};
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Serialises one 32-bit SPI mode-0 frame, two clk cycles per bit, and collects MISO samples.
module spi_frame_shifter
    import mem_spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  spi_miso,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    output logic                  frameEnd,
    output logic [7:0]            rxByte
);

    logic                  busy;
    logic                  phaseB;
    logic [4:0]            bitCnt;
    logic [FRAME_BITS-1:0] txShift;

    // Last cycle of the frame: phase B of bit 0.
    assign frameEnd = busy && phaseB && (bitCnt == 5'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            phaseB   <= 1'b0;
            bitCnt   <= '0;
            txShift  <= '0;
            rxByte   <= '0;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            phaseB   <= 1'b0;
            bitCnt   <= 5'(FRAME_BITS - 1);
            txShift  <= frame;
            spi_sck  <= 1'b0;
            spi_mosi <= frame[FRAME_BITS-1];
        end else if (busy) begin
            if (!phaseB) begin
                // Rising SCK edge: the slave's bit is sampled here.
                phaseB  <= 1'b1;
                spi_sck <= 1'b1;
                rxByte  <= {rxByte[6:0], spi_miso};
            end else begin
                phaseB  <= 1'b0;
                spi_sck <= 1'b0;
                if (bitCnt == 5'd0) begin
                    busy     <= 1'b0;
                    spi_mosi <= 1'b0;
                end else begin
                    bitCnt   <= bitCnt - 5'd1;
                    txShift  <= txShift << 1;
                    spi_mosi <= txShift[FRAME_BITS-2];
                end
            end
        end
    end

endmodule

// File: rtl/mem_spi_bridge.sv
// Accepts one CPU memory request at a time and runs it as a single SPI SRAM read/write frame.
module mem_spi_bridge
    import mem_spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    bridgeStateT           state;
    bridgeStateT           stateNext;
    logic                  isWrite;
    logic                  start;
    logic                  frameEnd;
    logic [7:0]            rxByte;
    logic [FRAME_BITS-1:0] frame;

    assign req_ready = (state == IDLE);
    assign start     = req_valid && req_ready;
    assign frame     = buildFrame(req_write, 16'(req_addr), 8'(req_wdata));

    spi_frame_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .frame    (frame),
        .spi_miso (spi_miso),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .frameEnd (frameEnd),
        .rxByte   (rxByte)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives stateNext and no latch is inferred.
        stateNext = state;
        unique case (state)
            IDLE:    if (start) stateNext = SHIFT;
            SHIFT:   if (frameEnd) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isWrite   <= 1'b0;
            spi_cs_n  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= (state == SHIFT) && frameEnd;
            if (start) begin
                isWrite  <= req_write;
                spi_cs_n <= 1'b0;
            end else if (frameEnd) begin
                spi_cs_n <= 1'b1;
            end
            // Read data is only committed at the end of a read; writes leave it untouched.
            if ((state == SHIFT) && frameEnd && !isWrite) begin
                rsp_rdata <= DATA_WIDTH'(rxByte);
            end
        end
    end

endmodule

// File: tb/tb_mem_spi_bridge.sv
// Self-checking bench: behavioural SPI SRAM slave plus a scoreboard of expected memory contents.
module tb_mem_spi_bridge;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso  = 1'b0;

    int total = 0;
    int bad   = 0;

    mem_spi_bridge #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- SRAM slave model and protocol monitor ----------------
    logic [7:0] sramMem [int];
    logic [7:0] expMem  [int];
    logic [7:0] expRdata = 8'h00;

    function automatic logic [7:0] initVal(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    function automatic logic [7:0] sramRead(input logic [15:0] a);
        return sramMem.exists(int'(a)) ? sramMem[int'(a)] : initVal(a);
    endfunction

    function automatic logic [7:0] expRead(input logic [15:0] a);
        return expMem.exists(int'(a)) ? expMem[int'(a)] : initVal(a);
    endfunction

    int          monRise      = 0;
    int          monCsLow     = 0;
    int          monFrames    = 0;
    int          monProtoErr  = 0;
    int          monLastRise  = 0;
    int          monLastCsLow = 0;
    logic [31:0] monBits      = '0;
    logic [31:0] monLastFrame = '0;
    logic [7:0]  monRdByte    = '0;
    logic        monIsRead    = 1'b0;
    logic        prevCs       = 1'b1;
    logic        prevSck      = 1'b0;
    logic        prevMosi     = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prevCs   = 1'b1;
            prevSck  = 1'b0;
            prevMosi = 1'b0;
            monRise  = 0;
            monCsLow = 0;
            monBits  = '0;
            spi_miso = 1'b0;
        end else begin
            if (prevCs && !spi_cs_n) begin
                if (spi_sck !== 1'b0) monProtoErr++;
                monRise   = 0;
                monCsLow  = 0;
                monBits   = '0;
                monIsRead = 1'b0;
            end
            if (!spi_cs_n) begin
                monCsLow++;
                if (spi_sck && !prevSck) begin
                    if (spi_mosi !== prevMosi) monProtoErr++;
                    monBits = {monBits[30:0], spi_mosi};
                    monRise++;
                end
                if (!spi_sck) begin
                    if (monRise == 24) begin
                        monIsRead = (monBits[23:16] == 8'h03);
                        monRdByte = sramRead(monBits[15:0]);
                    end
                    if (monRise >= 24 && monRise < 32 && monIsRead) spi_miso = monRdByte[31-monRise];
                    else spi_miso = 1'($urandom_range(0, 1));
                end
            end
            if (!prevCs && spi_cs_n) begin
                monLastFrame = monBits;
                monLastRise  = monRise;
                monLastCsLow = monCsLow;
                monFrames++;
                if (monBits[31:24] == 8'h02) sramMem[int'(monBits[23:8])] = monBits[7:0];
            end
            prevCs   = spi_cs_n;
            prevSck  = spi_sck;
            prevMosi = spi_mosi;
        end
    end

    // ---------------- transaction driver ----------------
    typedef struct {
        int          doneCycle;
        int          shiftErr;
        int          frames;
        int          rise;
        int          csLow;
        logic        readyBefore;
        logic        readyAfter;
        logic        rspAfter;
        logic        csDone;
        logic        sckDone;
        logic [7:0]  rdataDone;
        logic [7:0]  rdataAfter;
        logic [31:0] frame;
    } obsT;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } vecT;

    // Called just after a falling edge; returns just after the falling edge of cycle 66.
    task automatic runTransfer(input logic wr, input logic [15:0] addr, input logic [7:0] data, output obsT o);
        int framesBefore;
        framesBefore = monFrames;
        o.doneCycle = -1;
        o.shiftErr  = 0;
        o.csDone    = 1'b0;
        o.sckDone   = 1'b0;
        o.rdataDone = '0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        #1 o.readyBefore = req_ready;
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_valid = 1'b0;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom);
                req_wdata = 8'($urandom);
            end
            if (n == 20) req_valid = 1'b1;
            if (n == 21) req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                o.doneCycle = n;
                o.csDone    = spi_cs_n;
                o.sckDone   = spi_sck;
                o.rdataDone = rsp_rdata;
                break;
            end
            if (spi_cs_n !== 1'b0 || req_ready !== 1'b0) o.shiftErr++;
        end
        @(negedge clk);
        o.readyAfter = req_ready;
        o.rspAfter   = rsp_valid;
        o.rdataAfter = rsp_rdata;
        o.frame      = monLastFrame;
        o.rise       = monLastRise;
        o.csLow      = monLastCsLow;
        o.frames     = monFrames - framesBefore;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        total++; if (spi_cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
        total++; if (spi_sck !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
        total++; if (spi_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h want 00", rsp_rdata); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({req_ready, spi_cs_n, rsp_valid} !== 3'b110) begin
            bad++; $display("FAIL post_reset_idle: got %b want 110", {req_ready, spi_cs_n, rsp_valid});
        end
    endtask

    task automatic test_transfers();
        vecT         vecs[$];
        vecT         v;
        obsT         o;
        logic [31:0] expFrame;
        sramMem[32'h00FF] = 8'h3C; expMem[32'h00FF] = 8'h3C;
        sramMem[32'hFFFF] = 8'hFF; expMem[32'hFFFF] = 8'hFF;
        v = '{1'b1, 16'h0010, 8'h5A}; vecs.push_back(v);
        v = '{1'b0, 16'hFFFF, 8'h77}; vecs.push_back(v);
        v = '{1'b1, 16'h1234, 8'hA5}; vecs.push_back(v);
        v = '{1'b0, 16'h00FF, 8'h00}; vecs.push_back(v);
        v = '{1'b1, 16'hFFFF, 8'hFF}; vecs.push_back(v);
        v = '{1'b0, 16'h1234, 8'h00}; vecs.push_back(v);
        v = '{1'b0, 16'h0010, 8'h00}; vecs.push_back(v);
        for (int i = 0; i < 12; i++) begin
            v.wr   = 1'($urandom_range(0, 1));
            v.addr = $urandom_range(0, 1) ? 16'($urandom_range(0, 7)) : (16'hFFF8 | 16'($urandom_range(0, 7)));
            v.data = 8'($urandom);
            vecs.push_back(v);
        end
        foreach (vecs[i]) begin
            expFrame = {vecs[i].wr ? 8'h02 : 8'h03, vecs[i].addr, vecs[i].wr ? vecs[i].data : 8'h00};
            if (vecs[i].wr) expMem[int'(vecs[i].addr)] = vecs[i].data;
            else expRdata = expRead(vecs[i].addr);
            runTransfer(vecs[i].wr, vecs[i].addr, vecs[i].data, o);
            total++; if (o.doneCycle !== 65) begin bad++; $display("FAIL xfer%0d done_cycle: got %0d want 65", i, o.doneCycle); end
            total++; if (o.frame !== expFrame) begin bad++; $display("FAIL xfer%0d mosi_frame: got %h want %h", i, o.frame, expFrame); end
            total++; if (o.rise !== 32) begin bad++; $display("FAIL xfer%0d sck_rises: got %0d want 32", i, o.rise); end
            total++; if (o.csLow !== 64) begin bad++; $display("FAIL xfer%0d cs_low_cycles: got %0d want 64", i, o.csLow); end
            total++; if (o.frames !== 1) begin bad++; $display("FAIL xfer%0d frame_count: got %0d want 1", i, o.frames); end
            total++; if (o.shiftErr !== 0) begin bad++; $display("FAIL xfer%0d shift_cs_ready: got %0d bad cycles want 0", i, o.shiftErr); end
            total++; if (monProtoErr !== 0) begin bad++; $display("FAIL xfer%0d spi_protocol: got %0d errors want 0", i, monProtoErr); end
            total++; if ({o.csDone, o.sckDone} !== 2'b10) begin bad++; $display("FAIL xfer%0d done_cs_sck: got %b want 10", i, {o.csDone, o.sckDone}); end
            total++; if (o.rdataDone !== expRdata) begin bad++; $display("FAIL xfer%0d rdata_done: got %h want %h", i, o.rdataDone, expRdata); end
            total++; if (o.rdataAfter !== expRdata) begin bad++; $display("FAIL xfer%0d rdata_hold: got %h want %h", i, o.rdataAfter, expRdata); end
            total++; if ({o.readyBefore, o.readyAfter, o.rspAfter} !== 3'b110) begin
                bad++; $display("FAIL xfer%0d handshake: got %b want 110", i, {o.readyBefore, o.readyAfter, o.rspAfter});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] aAddr;
        logic [7:0]  aData;
        logic [31:0] frameA;
        logic [31:0] frameB;
        logic [7:0]  rdata2;
        logic        ready66;
        logic        secondStarted;
        int          done1;
        int          done2;
        int          gap;
        aAddr = 16'h0100 | 16'($urandom_range(0, 7));
        aData = 8'($urandom);
        done1 = -1; done2 = -1; gap = 0; secondStarted = 1'b0;
        ready66 = 1'b0; frameA = '0; frameB = '0; rdata2 = '0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = aAddr; req_wdata = aData;
        @(posedge clk);
        for (int n = 1; n <= 140; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom);
                req_wdata = 8'($urandom);
            end
            if (n == 40) begin req_write = 1'b0; req_addr = aAddr; req_wdata = 8'($urandom); end
            if (n == 67) req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                if (done1 < 0) done1 = n;
                else begin done2 = n; rdata2 = rsp_rdata; end
            end
            if (n == 66) begin ready66 = req_ready; frameA = monLastFrame; end
            if (n >= 65 && !secondStarted) begin
                if (spi_cs_n === 1'b1) gap++;
                else secondStarted = 1'b1;
            end
            if (n == 132) begin frameB = monLastFrame; break; end
        end
        expMem[int'(aAddr)] = aData;
        expRdata = aData;
        total++; if (done1 !== 65) begin bad++; $display("FAIL b2b_first_done: got %0d want 65", done1); end
        total++; if (ready66 !== 1'b1) begin bad++; $display("FAIL b2b_ready_66: got %b want 1", ready66); end
        total++; if (gap !== 2) begin bad++; $display("FAIL b2b_cs_gap: got %0d want 2", gap); end
        total++; if (done2 !== 131) begin bad++; $display("FAIL b2b_second_done: got %0d want 131", done2); end
        total++; if (frameA !== {8'h02, aAddr, aData}) begin bad++; $display("FAIL b2b_frame_a: got %h want %h", frameA, {8'h02, aAddr, aData}); end
        total++; if (frameB !== {8'h03, aAddr, 8'h00}) begin bad++; $display("FAIL b2b_frame_b: got %h want %h", frameB, {8'h03, aAddr, 8'h00}); end
        total++; if (rdata2 !== expRdata) begin bad++; $display("FAIL b2b_read_back: got %h want %h", rdata2, expRdata); end
    endtask

    task automatic test_reset_mid_frame();
        obsT  o;
        logic sawRsp;
        logic sck30;
        sawRsp = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0033; req_wdata = 8'($urandom);
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (rsp_valid === 1'b1) sawRsp = 1'b1;
        end
        sck30 = spi_sck;
        #2 rst_n = 1'b0;
        #1;
        total++; if (sck30 !== 1'b1) begin bad++; $display("FAIL abort_sck_before: got %b want 1", sck30); end
        total++; if ({spi_cs_n, spi_sck, spi_mosi} !== 3'b100) begin
            bad++; $display("FAIL abort_spi_lines: got %b want 100", {spi_cs_n, spi_sck, spi_mosi});
        end
        total++; if ({req_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL abort_state: got %b want 10", {req_ready, rsp_valid}); end
        total++; if (rsp_rdata !== 8'h00) begin bad++; $display("FAIL abort_rdata: got %h want 00", rsp_rdata); end
        expRdata = 8'h00;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) sawRsp = 1'b1;
        end
        total++; if (sawRsp !== 1'b0) begin bad++; $display("FAIL abort_no_rsp: got %b want 0", sawRsp); end
        expRdata = expRead(16'h0001);
        runTransfer(1'b0, 16'h0001, 8'h00, o);
        total++; if (o.doneCycle !== 65) begin bad++; $display("FAIL after_abort_done: got %0d want 65", o.doneCycle); end
        total++; if (o.frame !== 32'h03000100) begin bad++; $display("FAIL after_abort_frame: got %h want 03000100", o.frame); end
        total++; if (o.frames !== 1) begin bad++; $display("FAIL after_abort_frames: got %0d want 1", o.frames); end
        total++; if (o.rdataDone !== expRdata) begin bad++; $display("FAIL after_abort_rdata: got %h want %h", o.rdataDone, expRdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_transfers();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
